// File: rtl/control_display_bcd.sv
// Sequential binary-to-BCD converter feeding a multiplexed 7-segment scan.
// Ports: clk, rst_n (async low), binario/cargar in; ocupado, listo, error,
//   codigo (digit code to decoder), anodo (active-low one-hot digit enable).
module control_display_bcd #(
    parameter int WIDTH       = 14,
    parameter int N_DIG       = 4,
    parameter int DIV         = 50000,
    parameter int BLANK_CEROS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] binario,
    input  logic             cargar,
    output logic             ocupado,
    output logic             listo,
    output logic             error,
    output logic [3:0]       codigo,
    output logic [N_DIG-1:0] anodo
);

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam int BCD_W = 4 * N_DIG;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PRE_W = $clog2(DIV);
    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [63:0] MAX_VAL = 64'(pow10(N_DIG) - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CONV  = 2'd1;
    localparam logic [1:0] S_CARGA = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [BCD_W-1:0] dig_q, dig_d;
    logic             ocupado_q, ocupado_d;
    logic             listo_q, listo_d;
    logic             error_q, error_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       codigo_q, codigo_d;
    logic [N_DIG-1:0] anodo_q, anodo_d;

    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W+WIDTH-1:0] cat_sh;

    // Conversion FSM: one double-dabble step per CONV cycle
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        dig_d   = dig_q;
        error_d = error_q;
        listo_d = 1'b0;
        bcd_adj = bcd_q;
        for (int i = 0; i < N_DIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        // The MSB of the accumulator falls off here on overflow
        cat_sh = {bcd_adj, shift_q} << 1;
        unique case (state_q)
            S_IDLE: begin
                if (cargar) begin
                    shift_d = binario;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 64'(binario) > MAX_VAL;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                bcd_d   = cat_sh[BCD_W+WIDTH-1:WIDTH];
                shift_d = cat_sh[WIDTH-1:0];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1))
                    state_d = S_CARGA;
            end
            S_CARGA: begin
                dig_d   = ovf_q ? '1 : bcd_q;
                error_d = ovf_q;
                listo_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        ocupado_d = (state_d != S_IDLE);
    end

    logic [N_DIG-1:0] blank;
    logic             zero_above;
    logic [3:0]       sel;
    logic             sel_blank;

    // Scan: prescaler, digit index, leading-zero blanking
    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        idx_d = idx_q;
        if (pre_q == PRE_W'(DIV - 1)) begin
            pre_d = '0;
            if (idx_q == IDX_W'(N_DIG - 1))
                idx_d = '0;
            else
                idx_d = idx_q + IDX_W'(1);
        end
        blank      = '0;
        zero_above = 1'b1;
        for (int i = N_DIG - 1; i > 0; i--) begin
            zero_above = zero_above && (dig_q[4*i +: 4] == 4'd0);
            blank[i]   = (BLANK_CEROS != 0) && zero_above;
        end
        sel       = 4'hF;
        sel_blank = 1'b0;
        for (int i = 0; i < N_DIG; i++) begin
            if (IDX_W'(i) == idx_q) begin
                sel       = dig_q[4*i +: 4];
                sel_blank = blank[i];
            end
        end
        codigo_d = sel_blank ? 4'hF : sel;
        anodo_d  = ~(N_DIG'(1) << idx_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            dig_q     <= '0;
            ocupado_q <= 1'b0;
            listo_q   <= 1'b0;
            error_q   <= 1'b0;
            pre_q     <= '0;
            idx_q     <= '0;
            codigo_q  <= 4'hF;
            anodo_q   <= '1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            dig_q     <= dig_d;
            ocupado_q <= ocupado_d;
            listo_q   <= listo_d;
            error_q   <= error_d;
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            codigo_q  <= codigo_d;
            anodo_q   <= anodo_d;
        end
    end

    assign ocupado = ocupado_q;
    assign listo   = listo_q;
    assign error   = error_q;
    assign codigo  = codigo_q;
    assign anodo   = anodo_q;

endmodule
